matmul_job_sched: RTL and testbench

- Sequences the 2x2 8-bit matrix-multiply datapath and shares it between two requesters (req0 = core, req1 = DMA).
- Accepts one job at a time from a valid/ready request port and arbitrates round-robin.
- Presents the operands and holds the datapath enable for the pipeline latency, then captures the four 32-bit products and returns them on a valid/ready response port.

---
 rtl/matmul_job_sched.sv | 157 +++++++++++++++
 tb/tb_matmul_job_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_job_sched.sv
// matmul_job_sched: shares a 2x2 8-bit matrix-multiply datapath between two
// requesters (0 = core, 1 = DMA). One job is in flight at a time. The block
// latches the operands, holds the datapath enable for LATENCY cycles, captures
// the four products and returns them on the owner's response port.
//
// Handshake rule (request and response ports alike): a transfer happens on a
// rising clock edge where valid and ready are both high. The sender holds valid
// and its payload steady until that edge. A request ready depends only on the
// state, the last grant and the request valids. A response valid depends only
// on registered state. Ready is never used to produce valid.
module matmul_job_sched #(
   parameter int LATENCY = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             resp0_valid,
   input  logic             resp0_ready,
   output logic             resp1_valid,
   input  logic             resp1_ready,
   output logic [127:0]     resp_data,
   output logic             mm_en,
   output logic [31:0]      mm_a,
   output logic [31:0]      mm_b,
   input  logic [127:0]     mm_p,
   output logic             busy,
   output logic [CNT_W-1:0] job_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CAPT = 2'd2,
      RESP = 2'd3
   } state_t;

   // RUN counts down from LATENCY-1 to 0, so it lasts exactly LATENCY cycles.
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t           state_q, state_d;
   logic [3:0]       cnt_q;
   logic             owner_q;
   logic             last_grant_q;
   logic [31:0]      mm_a_q, mm_b_q;
   logic [127:0]     resp_data_q;
   logic             resp0_valid_q, resp1_valid_q;
   logic [CNT_W-1:0] job_count_q;

   logic             grant;
   logic             accept;
   logic             resp_hs;

   // Round-robin grant: a lone requester wins; on contention the requester
   // that did not win last time goes first.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Ready only in IDLE and only for the granted requester.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state_q == IDLE) begin
         req0_ready = req0_valid && (grant == 1'b0);
         req1_ready = req1_valid && (grant == 1'b1);
      end
   end

   assign accept  = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign resp_hs = (state_q == RESP) &&
                    (owner_q ? resp1_ready : resp0_ready);

   // Next-state logic for the job sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN:  if (cnt_q == 4'd0) state_d = CAPT;
         CAPT: state_d = RESP;
         RESP: if (resp_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register plus all job-tracking registers; reset drops any job.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         mm_a_q        <= 32'd0;
         mm_b_q        <= 32'd0;
         resp_data_q   <= 128'd0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
         job_count_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  mm_a_q       <= grant ? req1_a : req0_a;
                  mm_b_q       <= grant ? req1_b : req0_b;
                  owner_q      <= grant;
                  last_grant_q <= grant;
                  cnt_q        <= CNT_INIT;
               end
            end
            RUN: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            CAPT: begin
               resp_data_q <= mm_p;
               if (owner_q) begin
                  resp1_valid_q <= 1'b1;
               end else begin
                  resp0_valid_q <= 1'b1;
               end
            end
            RESP: begin
               if (resp_hs) begin
                  resp0_valid_q <= 1'b0;
                  resp1_valid_q <= 1'b0;
                  job_count_q   <= job_count_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mm_en       = (state_q == RUN);
   assign mm_a        = mm_a_q;
   assign mm_b        = mm_b_q;
   assign resp_data   = resp_data_q;
   assign resp0_valid = resp0_valid_q;
   assign resp1_valid = resp1_valid_q;
   assign busy        = (state_q != IDLE);
   assign job_count   = job_count_q;

endmodule

// File: tb/tb_matmul_job_sched.sv
// Bench for matmul_job_sched: a job-timeline model (offsets from the accept
// cycle) predicts every output each cycle; directed tests add literal checks.
module tb_matmul_job_sched;

   localparam int L = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic         req0_ready, req1_ready, resp0_valid, resp1_valid;
   logic [127:0] resp_data, mm_p;
   logic         mm_en, busy;
   logic [31:0]  mm_a, mm_b;
   logic [15:0]  job_count;

   logic         d2_req0_ready, d2_req1_ready, d2_resp0_valid, d2_resp1_valid;
   logic [127:0] d2_resp_data;
   logic         d2_mm_en, d2_busy;
   logic [31:0]  d2_mm_a, d2_mm_b;
   logic [1:0]   d2_job_count;

   int checks = 0;
   int errors = 0;

   // clock
   always #5 clk = ~clk;

   matmul_job_sched #(.LATENCY(L), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .mm_en(mm_en), .mm_a(mm_a), .mm_b(mm_b), .mm_p(mm_p),
      .busy(busy), .job_count(job_count)
   );

   // Narrow-counter instance driven in lockstep with the main one.
   matmul_job_sched #(.LATENCY(L), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(d2_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(d2_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(d2_resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(d2_resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(d2_resp_data), .mm_en(d2_mm_en), .mm_a(d2_mm_a), .mm_b(d2_mm_b), .mm_p(mm_p),
      .busy(d2_busy), .job_count(d2_job_count)
   );

   function automatic logic [127:0] matmul(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] a11, a12, a21, a22, b11, b12, b21, b22;
      a11 = {24'd0, a[7:0]};   a12 = {24'd0, a[15:8]};
      a21 = {24'd0, a[23:16]}; a22 = {24'd0, a[31:24]};
      b11 = {24'd0, b[7:0]};   b12 = {24'd0, b[15:8]};
      b21 = {24'd0, b[23:16]}; b22 = {24'd0, b[31:24]};
      return {a21 * b12 + a22 * b22, a21 * b11 + a22 * b21,
              a11 * b12 + a12 * b22, a11 * b11 + a12 * b21};
   endfunction

   // Datapath stand-in: multiply stage then sum stage, both gated by enable.
   logic [127:0] dp_s1 = '0, dp_s2 = '0;
   logic         dp_en_d = 1'b0;
   always @(posedge clk) begin
      if (mm_en) dp_s1 <= matmul(mm_a, mm_b);
      dp_en_d <= mm_en;
      if (dp_en_d) dp_s2 <= dp_s1;
   end
   assign mm_p = dp_s2;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one job timeline, expressed as offsets from the accept cycle.
   int           cyc = 0;
   bit           chk_on = 0;
   bit           m_active = 0;
   bit           m_last = 1;
   bit           m_own = 0;
   int           m_acc = 0;
   int           m_count = 0;
   logic [31:0]  m_a = '0, m_b = '0;
   logic [127:0] m_exp = '0, m_rdata = '0;
   int           glog[$];

   function automatic bit grant_of(input bit v0, input bit v1, input bit last);
      if (v0 && v1) return !last;
      return v1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_active = 0; m_last = 1; m_count = 0;
         m_a = '0; m_b = '0; m_rdata = '0;
         chk_on = 1;
      end else if (!m_active) begin
         if (req0_valid || req1_valid) begin
            m_own    = grant_of(req0_valid, req1_valid, m_last);
            m_last   = m_own;
            m_active = 1;
            m_acc    = cyc;
            m_a      = m_own ? req1_a : req0_a;
            m_b      = m_own ? req1_b : req0_b;
            m_exp    = matmul(m_a, m_b);
            glog.push_back(int'(m_own));
         end
      end else begin
         if (cyc - m_acc == L + 1) m_rdata = m_exp;
         if ((cyc - m_acc >= L + 2) && (m_own ? resp1_ready : resp0_ready)) begin
            m_active = 0;
            m_count++;
         end
      end
      cyc++;
   end

   // Per-cycle compare of both instances against the model.
   int  off;
   bit  e_en, e_v0, e_v1, e_r0, e_r1, g_now;
   int  en_cnt = 0;
   always @(negedge clk) begin
      if (mm_en) en_cnt++;
      if (chk_on) begin
         off   = cyc - m_acc;
         e_en  = m_active && off >= 1 && off <= L;
         e_v0  = m_active && off >= L + 2 && !m_own;
         e_v1  = m_active && off >= L + 2 && m_own;
         g_now = grant_of(req0_valid, req1_valid, m_last);
         e_r0  = !m_active && req0_valid && !g_now;
         e_r1  = !m_active && req1_valid && g_now;
         chk("busy", 128'(busy), 128'(m_active));
         chk("mm_en", 128'(mm_en), 128'(e_en));
         chk("mm_a", 128'(mm_a), 128'(m_a));
         chk("mm_b", 128'(mm_b), 128'(m_b));
         chk("resp0_valid", 128'(resp0_valid), 128'(e_v0));
         chk("resp1_valid", 128'(resp1_valid), 128'(e_v1));
         chk("resp_data", resp_data, m_rdata);
         chk("req0_ready", 128'(req0_ready), 128'(e_r0));
         chk("req1_ready", 128'(req1_ready), 128'(e_r1));
         chk("job_count", 128'(job_count), 128'(m_count % 65536));
         chk("d2_job_count", 128'(d2_job_count), 128'(m_count % 4));
         chk("d2_resp_data", d2_resp_data, m_rdata);
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Waits for the handshake of requester n; returns just after the accept edge.
   task automatic wait_accept(input bit n, input string name);
      for (int i = 0; i < 100; i++) begin
         #1;
         if (n ? req1_ready : req0_ready) begin
            step();
            return;
         end
         step();
      end
      chk({name, "_accept_timeout"}, 128'd0, 128'd1);
   endtask

   task automatic wait_count(input int target, input string name);
      for (int i = 0; i < 200; i++) begin
         if (m_count == target) return;
         step();
      end
      chk({name, "_done_timeout"}, 128'(m_count), 128'(target));
   endtask

   logic [1:0]   seq6 [5];
   logic [127:0] ff_exp;

   initial begin
      seq6[0] = 2'd1; seq6[1] = 2'd2; seq6[2] = 2'd3; seq6[3] = 2'd0; seq6[4] = 2'd1;
      ff_exp = {4{32'h0001FC02}};
      chk("model_pin_small", matmul(32'h04030201, 32'h08070605),
          {32'd50, 32'd43, 32'd22, 32'd19});
      chk("model_pin_ff", matmul(32'hFFFFFFFF, 32'hFFFFFFFF), ff_exp);

      step();
      do_reset();
      #1;
      chk("reset_busy", 128'(busy), 128'd0);
      chk("reset_count", 128'(job_count), 128'd0);

      // Test 1: single req0 job, result in cycle 4.
      req0_a = 32'h04030201; req0_b = 32'h08070605;
      resp0_ready = 1'b1;
      req0_valid = 1'b1;
      wait_accept(0, "t1");
      req0_valid = 1'b0;
      step(); step(); step();
      chk("t1_valid_cycle4", 128'(resp0_valid), 128'd1);
      chk("t1_data", resp_data, {32'd50, 32'd43, 32'd22, 32'd19});
      step();
      chk("t1_count", 128'(job_count), 128'd1);

      // Test 2: both requesters held valid for four jobs.
      do_reset();
      glog.delete();
      req0_a = 32'h01020304; req0_b = 32'h05060708;
      req1_a = 32'h11223344; req1_b = 32'h0A0B0C0D;
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_count(4, "t2");
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("t2_njobs", 128'(glog.size() >= 4), 128'd1);
      if (glog.size() >= 4) begin
         chk("t2_grant0", 128'(glog[0]), 128'd0);
         chk("t2_grant1", 128'(glog[1]), 128'd1);
         chk("t2_grant2", 128'(glog[2]), 128'd0);
         chk("t2_grant3", 128'(glog[3]), 128'd1);
      end

      // Test 3: response back-pressure while req1 waits.
      do_reset();
      resp0_ready = 1'b0; resp1_ready = 1'b1;
      req0_a = 32'h10203040; req0_b = 32'h01010101;
      req0_valid = 1'b1;
      wait_accept(0, "t3");
      req0_valid = 1'b0;
      req1_a = 32'h05050505; req1_b = 32'h02020202;
      req1_valid = 1'b1;
      for (int i = 0; i < 20 && !resp0_valid; i++) step();
      chk("t3_resp_seen", 128'(resp0_valid), 128'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t3_hold_valid", 128'(resp0_valid), 128'd1);
         chk("t3_hold_data", resp_data, matmul(32'h10203040, 32'h01010101));
         chk("t3_hold_req1_ready", 128'(req1_ready), 128'd0);
      end
      resp0_ready = 1'b1;
      step();
      chk("t3_req1_ready_next", 128'(req1_ready), 128'd1);
      wait_accept(1, "t3b");
      req1_valid = 1'b0;
      wait_count(2, "t3");

      // Test 4: saturated operands; enable high exactly LATENCY cycles.
      do_reset();
      req1_a = 32'hFFFFFFFF; req1_b = 32'hFFFFFFFF;
      en_cnt = 0;
      req1_valid = 1'b1;
      wait_accept(1, "t4");
      req1_valid = 1'b0;
      for (int i = 0; i < 20 && !resp1_valid; i++) step();
      chk("t4_data", resp_data, ff_exp);
      wait_count(1, "t4");
      step();
      chk("t4_en_cycles", 128'(en_cnt), 128'd2);

      // Test 5: reset during RUN drops the job.
      req0_a = 32'h02020202; req0_b = 32'h03030303;
      req0_valid = 1'b1;
      wait_accept(0, "t5");
      req0_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_busy", 128'(busy), 128'd0);
      chk("t5_mm_en", 128'(mm_en), 128'd0);
      chk("t5_count", 128'(job_count), 128'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t5_no_resp", 128'({resp0_valid, resp1_valid}), 128'd0);
      end
      req1_a = 32'h01010101; req1_b = 32'h01010101;
      req1_valid = 1'b1;
      wait_accept(1, "t5b");
      req1_valid = 1'b0;
      for (int i = 0; i < 20 && !resp1_valid; i++) step();
      chk("t5_data", resp_data, {4{32'd2}});
      wait_count(1, "t5");
      chk("t5_count_after", 128'(job_count), 128'd1);

      // Test 6: two-bit job counter wraps.
      do_reset();
      resp0_ready = 1'b1;
      for (int j = 0; j < 5; j++) begin
         req0_a = 32'(j + 1); req0_b = 32'(j + 2);
         req0_valid = 1'b1;
         wait_accept(0, "t6");
         req0_valid = 1'b0;
         wait_count(j + 1, "t6");
         chk("t6_wrap_count", 128'(d2_job_count), 128'(seq6[j]));
      end
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
